// File: rtl/paralelo_serial_framer_if.sv
// rtl/paralelo_serial_framer_if.sv - word handshake into the parallel-to-serial framer
interface paralelo_serial_framer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/paralelo_serial_framer.sv
// rtl/paralelo_serial_framer.sv - parallel-to-serial framer with idle fill; P2S_PARITY_EN appends an even-parity bit per frame
module paralelo_serial_framer #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] IDLE_PATTERN = 8'hBC,
  parameter bit               MSB_FIRST    = 1'b1
) (
  input  logic                    clk_32f,
  input  logic                    reset,
  paralelo_serial_framer_if.slave in_bus,
  output logic                    serial_out,
  output logic                    frame_start,
  output logic                    frame_data
);

`ifdef P2S_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int            CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] next_word;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             boundary;
  logic             xfer;
  logic             load_data;
  logic             next_bit;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign boundary        = (cnt == LAST);
  assign in_bus.in_ready = ~reset & (~hold_full | boundary);
  assign xfer            = in_bus.in_valid & in_bus.in_ready;

  // A held word always wins the boundary; an empty hold lets a same-cycle word bypass straight in.
  always_comb begin
    load_data = 1'b0;
    next_word = IDLE_PATTERN;
    if (hold_full) begin
      load_data = 1'b1;
      next_word = hold;
    end else if (xfer) begin
      load_data = 1'b1;
      next_word = in_bus.in_data;
    end
  end

`ifdef P2S_PARITY_EN
  logic parity;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (boundary) begin
      parity <= ^next_word;
    end
  end

  always_comb begin
    next_bit = first_bit(shreg);
    if (cnt == CW'(WIDTH - 1)) begin
      next_bit = parity;
    end
  end
`else
  always_comb begin
    next_bit = first_bit(shreg);
  end
`endif

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      shreg       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      cnt         <= LAST;
      serial_out  <= 1'b0;
      frame_start <= 1'b0;
      frame_data  <= 1'b0;
    end else if (boundary) begin
      cnt         <= '0;
      frame_start <= 1'b1;
      frame_data  <= load_data;
      serial_out  <= first_bit(next_word);
      shreg       <= shift_word(next_word);
      if (hold_full && xfer) begin
        hold <= in_bus.in_data;
      end else if (hold_full) begin
        hold_full <= 1'b0;
      end
    end else begin
      cnt         <= cnt + 1'b1;
      frame_start <= 1'b0;
      serial_out  <= next_bit;
      shreg       <= shift_word(shreg);
      if (xfer) begin
        hold      <= in_bus.in_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial_framer.sv
// tb/tb_paralelo_serial_framer.sv - scoreboard bench for the parallel-to-serial framer (MSB-first and LSB-first instances)
module tb_paralelo_serial_framer;
  localparam int         WIDTH = 8;
  localparam logic [7:0] IDLE  = 8'hBC;
`ifdef P2S_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic clk_32f = 1'b0;
  logic reset;
  always #5 clk_32f = ~clk_32f;

  paralelo_serial_framer_if #(.WIDTH(WIDTH)) bus_m ();
  paralelo_serial_framer_if #(.WIDTH(WIDTH)) bus_l ();

  logic so_m, fs_m, fd_m, so_l, fs_l, fd_l;

  paralelo_serial_framer #(.WIDTH(WIDTH), .IDLE_PATTERN(IDLE), .MSB_FIRST(1'b1)) dut (
    .clk_32f(clk_32f), .reset(reset), .in_bus(bus_m.slave),
    .serial_out(so_m), .frame_start(fs_m), .frame_data(fd_m));

  paralelo_serial_framer #(.WIDTH(WIDTH), .IDLE_PATTERN(IDLE), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_32f(clk_32f), .reset(reset), .in_bus(bus_l.slave),
    .serial_out(so_l), .frame_start(fs_l), .frame_data(fd_l));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int          bitcnt[2];
  logic [15:0] got[2];
  logic [15:0] last_data_got[2];
  logic [15:0] last_idle_got[2];
  logic        cur_data[2];
  int          data_run[2];
  logic [7:0]  q_m[$];
  logic [7:0]  q_l[$];
  int          t_m[$];
  int          t_l[$];
  logic        xfer_m, xfer_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Bit i of the result is the i-th bit placed on the line.
  function automatic logic [15:0] exp_frame(input logic [7:0] w, input bit msb);
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) f[i] = msb ? w[WIDTH-1-i] : w[i];
    if (FL > WIDTH) f[WIDTH] = ^w;
    return f;
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q_m.size() : q_l.size();
  endfunction

  function automatic int qfront_t(input int k);
    return (k == 0) ? t_m[0] : t_l[0];
  endfunction

  task automatic qpush(input int k, input logic [7:0] w, input int t);
    if (k == 0) begin q_m.push_back(w); t_m.push_back(t); end
    else        begin q_l.push_back(w); t_l.push_back(t); end
  endtask

  task automatic qpop(input int k, output logic [7:0] w);
    if (k == 0) begin w = q_m.pop_front(); void'(t_m.pop_front()); end
    else        begin w = q_l.pop_front(); void'(t_l.pop_front()); end
  endtask

  // Ready whenever the last bit of a frame is on the line, or no accepted word is waiting behind the one in flight.
  function automatic logic exp_ready(input int k);
    int held;
    if (bitcnt[k] >= FL) return 1'b1;
    held = qsize(k) - (cur_data[k] ? 1 : 0);
    return (held == 0);
  endfunction

  task automatic monitor(input int k, input logic so, input logic fs, input logic fd);
    string      nm;
    logic [7:0] w;
    int         lat;
    nm = (k == 0) ? "msb" : "lsb";
    if (reset) begin
      chk({nm, "_reset_serial_out"}, so, 0);
      chk({nm, "_reset_frame_start"}, fs, 0);
      chk({nm, "_reset_frame_data"}, fd, 0);
      bitcnt[k] = FL; got[k] = '0; cur_data[k] = 1'b0; data_run[k] = 0;
      if (k == 0) begin q_m.delete(); t_m.delete(); end
      else        begin q_l.delete(); t_l.delete(); end
      return;
    end
    if (fs) chk({nm, "_frame_length"}, bitcnt[k], FL);
    else if (bitcnt[k] >= FL) chk({nm, "_frame_start_on_time"}, fs, 1);
    if (fs || bitcnt[k] >= FL) begin
      bitcnt[k] = 0; got[k] = '0; cur_data[k] = fd;
      if (fd) begin
        chk({nm, "_data_frame_has_word"}, qsize(k) > 0, 1);
        if (qsize(k) > 0 && qfront_t(k) >= 0) begin
          lat = cyc - qfront_t(k) + 1;
          chk({nm, "_latency_in_range"}, (lat >= 1 && lat <= FL), 1);
        end
      end
    end else begin
      chk({nm, "_frame_data_steady"}, fd, cur_data[k]);
    end
    got[k][bitcnt[k]] = so;
    bitcnt[k]++;
    if (bitcnt[k] == FL) begin
      if (cur_data[k]) begin
        if (qsize(k) > 0) begin
          qpop(k, w);
          chk({nm, "_data_frame_bits"}, got[k], exp_frame(w, k == 0));
          data_run[k]++;
        end
        last_data_got[k] = got[k];
      end else begin
        chk({nm, "_idle_frame_bits"}, got[k], exp_frame(IDLE, k == 0));
        last_idle_got[k] = got[k];
        data_run[k] = 0;
      end
    end
  endtask

  task automatic cycle();
    #1;
    xfer_m = 1'b0;
    xfer_l = 1'b0;
    if (!reset) begin
      chk("msb_in_ready", bus_m.in_ready, exp_ready(0));
      chk("lsb_in_ready", bus_l.in_ready, exp_ready(1));
      xfer_m = bus_m.in_valid & bus_m.in_ready;
      xfer_l = bus_l.in_valid & bus_l.in_ready;
      if (xfer_m) qpush(0, bus_m.in_data, (qsize(0) == 0) ? cyc + 1 : -1);
      if (xfer_l) qpush(1, bus_l.in_data, (qsize(1) == 0) ? cyc + 1 : -1);
    end
    @(posedge clk_32f);
    cyc++;
    @(negedge clk_32f);
    monitor(0, so_m, fs_m, fd_m);
    monitor(1, so_l, fs_l, fd_l);
  endtask

  task automatic stream_m(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int count, output int accepted);
    logic [7:0] words[3];
    int n;
    words[0] = w0; words[1] = w1; words[2] = w2;
    accepted = 0; n = 0;
    bus_m.in_valid = 1'b1;
    bus_m.in_data  = words[0];
    while (accepted < count && n < 8 * FL) begin
      cycle();
      n++;
      if (xfer_m) begin
        accepted++;
        if (accepted < count) bus_m.in_data = words[accepted];
        else begin bus_m.in_valid = 1'b0; bus_m.in_data = 8'h66; end
      end
    end
    bus_m.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int acc;
    for (int k = 0; k < 2; k++) begin
      bitcnt[k] = FL; got[k] = '0; cur_data[k] = 1'b0; data_run[k] = 0;
      last_data_got[k] = '0; last_idle_got[k] = '0;
    end
    reset = 1'b1;
    bus_m.in_valid = 1'b0; bus_m.in_data = '0;
    bus_l.in_valid = 1'b0; bus_l.in_data = '0;
    @(negedge clk_32f);

    // Reset, then idle fill only.
    repeat (3) cycle();
    reset = 1'b0;
    repeat (3 * FL) cycle();
    chk("idle_pattern_msb_first", last_idle_got[0], (FL > WIDTH) ? 16'h013D : 16'h003D);

    // Single word mid idle frame; later in_data changes must be ignored.
    n = 0;
    while (bitcnt[0] != 3 && n < 4 * FL) begin cycle(); n++; end
    chk("wait_mid_idle", bitcnt[0], 3);
    bus_m.in_valid = 1'b1; bus_m.in_data = 8'hA5;
    cycle();
    chk("a5_accepted", xfer_m, 1);
    bus_m.in_valid = 1'b0; bus_m.in_data = 8'hFF;
    repeat (3 * FL) cycle();
    chk("a5_drained", qsize(0), 0);
    chk("a5_bits", last_data_got[0], 16'h00A5);

    // Gapless back-to-back stream.
    stream_m(8'h01, 8'hFF, 8'h3C, 3, acc);
    chk("stream_all_accepted", acc, 3);
    n = 0;
    while (qsize(0) != 0 && n < 6 * FL) begin cycle(); n++; end
    chk("stream_drained", qsize(0), 0);
    chk("stream_gapless", data_run[0], 3);
    repeat (2 * FL) cycle();

    // Reset mid-frame with a second word held.
    stream_m(8'hA5, 8'h5A, 8'h00, 2, acc);
    chk("abort_words_accepted", acc, 2);
    n = 0;
    while (!(cur_data[0] && bitcnt[0] == 4 && qsize(0) == 2) && n < 4 * FL) begin cycle(); n++; end
    chk("abort_at_bit4_with_held", qsize(0), 2);
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (3 * FL) cycle();
    chk("after_abort_idle_only", data_run[0], 0);

    // LSB-first instance.
    n = 0;
    while (bitcnt[1] != 5 && n < 4 * FL) begin cycle(); n++; end
    chk("wait_lsb_slot", bitcnt[1], 5);
    bus_l.in_valid = 1'b1; bus_l.in_data = 8'h80;
    cycle();
    chk("lsb_80_accepted", xfer_l, 1);
    bus_l.in_valid = 1'b0; bus_l.in_data = 8'h00;
    repeat (3 * FL) cycle();
    chk("lsb_drained", qsize(1), 0);
    chk("lsb_80_bits", last_data_got[1], (FL > WIDTH) ? 16'h0180 : 16'h0080);

`ifdef P2S_PARITY_EN
    bus_m.in_valid = 1'b1; bus_m.in_data = 8'h07;
    cycle();
    chk("parity_07_accepted", xfer_m, 1);
    bus_m.in_valid = 1'b0;
    repeat (3 * FL) cycle();
    chk("parity_07_bits", last_data_got[0], 16'h01E0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
